irq_arbiter: RTL and testbench
==============================

# irq_arbiter

Multi-source interrupt arbiter feeding the single `irq` input of the core's PC-coercion interrupt block. Latches rising edges from up to `NUM_SOURCES` peripheral lines, masks them with an enable vector, selects one winner by fixed or round-robin priority, and holds `irq` until the core confirms ISR entry. It then reports the winning source ID and blocks further requests until `rfi` is executed (`pc_mux_control == PC_SAVE`).

## Interface
- `NUM_SOURCES`, default 4: number of interrupt source lines, 2..16.
- `PC_SAVE`, default 2'h3: `pc_mux_control` encoding of `rfi`.
- `ROUND_ROBIN`, default 0: 0 = fixed priority (index 0 highest); 1 = rotating priority.
- `TIMEOUT_CYCLES`, default 15: REQUEST cycles without `irq_taken` before withdrawing; range 1..255.
- `instr_clock`  in  1  sole clock, rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `irq_src`  in  NUM_SOURCES  level source lines, rising-edge detected.
- `irq_enable`  in  NUM_SOURCES  per-source arbitration mask.
- `irq_taken`  in  1  one-cycle pulse: core has coerced PC to the interrupt vector.
- `pc_mux_control`  in  2  core PC mux select, used for `rfi` detection.
- `irq`  out  1  request to the interrupt block, registered.
- `irq_cause`  out  SRC_W ($clog2(NUM_SOURCES))  ID of the requested or in-service source.
- `irq_busy`  out  1  high in SERVICE.
- `irq_pending`  out  NUM_SOURCES  latched pending bits.

## Operation
- Edge detect: `src_q` registers `irq_src`. `pending[i]` sets when `irq_src[i] & ~src_q[i]`. A line already high when reset releases is captured on the first post-reset edge.
- Pending bits latch regardless of `irq_enable`. The mask only gates arbitration.
- `pending[i]` clears only when source i is taken. If a new edge for source i arrives in the same cycle as its clear, the set wins.
- Winner: the lowest index in `pending & irq_enable`, searching upward from `rr_ptr` with wrap. `rr_ptr` is fixed at 0 when `ROUND_ROBIN == 0`.
- FSM states are IDLE, REQUEST and SERVICE.
- IDLE: if any enabled pending bit exists, latch the winner into `irq_cause`, load `timer = 0`, and go to REQUEST.
- REQUEST: `irq` = 1.
  - `irq_taken`: clear `pending[irq_cause]`; if round-robin, set `rr_ptr = (irq_cause + 1) mod NUM_SOURCES`; go to SERVICE.
  - `irq_enable[irq_cause]` low: withdraw to IDLE. Pending is kept.
  - `timer == TIMEOUT_CYCLES - 1`: withdraw to IDLE. Pending is kept.
  - Precedence: taken > enable-drop > timeout.
- SERVICE: `irq` = 0, `irq_busy` = 1, `irq_cause` held. `pc_mux_control == PC_SAVE` returns to IDLE. New edges keep latching during SERVICE.
- `irq_taken` outside REQUEST is ignored. `rfi` outside SERVICE is ignored.
- `irq_cause` keeps its last value in IDLE.

## Timing
- Reset (synchronous, `reset_n` low at a rising edge): state IDLE; `irq`, `irq_busy`, `irq_cause`, `irq_pending`, `src_q`, `rr_ptr` and `timer` all become 0. Reset mid-REQUEST or mid-SERVICE drops everything, including pending bits.
- Source edge sampled at edge k: `pending` is visible after edge k. At edge k+1, `irq` and `irq_cause` go high/valid, so the latency is 2 edges.
- `irq_taken` at edge m: `irq` is low after edge m, and `irq_busy` is high after edge m.
- `rfi` sampled at edge n: IDLE after edge n. The earliest next `irq` is after edge n+1.
- Timeout: `irq` is high for exactly `TIMEOUT_CYCLES` cycles, then low for at least 1 cycle (the IDLE re-arbitration cycle).
- All outputs are registered. No combinational input-to-output paths.

## Structure
- Package `irq_pkg`:
  - `irq_state_t` enum {IDLE, REQUEST, SERVICE}.
  - `PC_SAVE_DEFAULT` = 2'h3.
  - Function `src_w(n)` returning $clog2(n).
- Sub-module `irq_priority_picker`: combinational rotating priority encoder with inputs `req[NUM_SOURCES]` and `start[SRC_W]`, and outputs `grant_id` and `grant_valid`. It is reused for both modes, with `start` tied to 0 for fixed priority.
- Top level holds the edge detector, pending register, FSM, timer and `rr_ptr`.

## Test plan
- Reset, single source: pulse `irq_src[2]` with all sources enabled. Expect `irq` high 2 edges later with `irq_cause = 2`. Pulse `irq_taken`: expect `irq` = 0, `irq_busy` = 1, `pending[2]` = 0. Drive `pc_mux_control = 3`: expect `irq_busy` = 0.
- Fixed priority: raise sources 1 and 3 in the same cycle. Expect cause 1 first. After `rfi`, expect cause 3. `irq_pending` reads 4'b1010, then 4'b1000, then 0.
- Round-robin (`ROUND_ROBIN = 1`): keep sources 0 and 1 re-pending every service. Expect causes to alternate 0, 1, 0, 1.
- Timeout: never assert `irq_taken`. Expect `irq` high for exactly 15 cycles, low for 1 cycle, then re-requested with the same cause. `pending` stays set throughout.
- Mask and simultaneous events:
  - Disable source 0 while its `irq` is high: expect withdrawal after 1 edge.
  - Re-enable it: expect a new request.
  - New edge on source 0 coincident with `irq_taken`: `pending[0]` must remain 1.
- Reset mid-SERVICE: assert `reset_n` = 0 for 1 edge. All outputs must be 0, and a subsequent `rfi` must have no effect.

Source files
------------

// File: rtl/irq_arbiter_pkg.sv
// irq_pkg: shared FSM state type, rfi encoding default and ID-width helper
package irq_pkg;
  typedef enum logic [1:0] {IDLE, REQUEST, SERVICE} irq_state_t;
  localparam logic [1:0] PC_SAVE_DEFAULT = 2'h3;
  function automatic int src_w(input int n);
    return $clog2(n);
  endfunction
endpackage

// File: rtl/irq_arbiter_if.sv
// irq_arbiter_if: peripheral/core signal bundle of the interrupt arbiter
// slave (arbiter): in irq_src, irq_enable, irq_taken, pc_mux_control; out irq, irq_cause, irq_busy, irq_pending
// master (core/peripheral side): the mirror image
interface irq_arbiter_if import irq_pkg::*; #(parameter int NUM_SOURCES = 4);
  localparam int SRC_W = src_w(NUM_SOURCES);
  logic [NUM_SOURCES-1:0] irq_src;
  logic [NUM_SOURCES-1:0] irq_enable;
  logic irq_taken;
  logic [1:0] pc_mux_control;
  logic irq;
  logic [SRC_W-1:0] irq_cause;
  logic irq_busy;
  logic [NUM_SOURCES-1:0] irq_pending;
  modport master (output irq_src, irq_enable, irq_taken, pc_mux_control,
                  input irq, irq_cause, irq_busy, irq_pending);
  modport slave (input irq_src, irq_enable, irq_taken, pc_mux_control,
                 output irq, irq_cause, irq_busy, irq_pending);
endinterface

// File: rtl/irq_priority_picker.sv
// irq_priority_picker: rotating priority encoder, first set req at or above start with wrap
// in req, start; out grant_id, grant_valid
module irq_priority_picker import irq_pkg::*; #(
  parameter int NUM_SOURCES = 4,
  parameter int SRC_W = src_w(NUM_SOURCES)
) (
  input  logic [NUM_SOURCES-1:0] req,
  input  logic [SRC_W-1:0]       start,
  output logic [SRC_W-1:0]       grant_id,
  output logic                   grant_valid
);
  int idx;
  // Scan from the farthest offset down so the nearest one to start is written last.
  always_comb begin
    grant_id = '0;
    grant_valid = 1'b0;
    idx = 0;
    for (int k = NUM_SOURCES - 1; k >= 0; k--) begin
      idx = (int'(start) + k) % NUM_SOURCES;
      if (req[idx]) begin
        grant_id = SRC_W'(idx);
        grant_valid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/irq_arbiter.sv
// irq_arbiter: edge-latched multi-source interrupt arbiter with request/service handshake
// in instr_clock, reset_n (sync, active-low); bus: irq_arbiter_if.slave
module irq_arbiter import irq_pkg::*; #(
  parameter int NUM_SOURCES = 4,
  parameter logic [1:0] PC_SAVE = PC_SAVE_DEFAULT,
  parameter bit ROUND_ROBIN = 1'b0,
  parameter int TIMEOUT_CYCLES = 15
) (
  input logic instr_clock,
  input logic reset_n,
  irq_arbiter_if.slave bus
);
  localparam int SRC_W = src_w(NUM_SOURCES);
  irq_state_t state_q, state_d;
  logic [NUM_SOURCES-1:0] src_q, pend_q, pend_d, clr;
  logic [SRC_W-1:0] cause_q, cause_d, rr_q, rr_d, grant_id;
  logic [7:0] timer_q, timer_d;
  logic irq_q, busy_q, grant_valid;
  irq_priority_picker #(.NUM_SOURCES(NUM_SOURCES), .SRC_W(SRC_W)) u_pick (
    .req(pend_q & bus.irq_enable),
    .start(ROUND_ROBIN ? rr_q : '0),
    .grant_id(grant_id),
    .grant_valid(grant_valid)
  );
  // Edge set is OR'ed after the clear so a coincident new edge survives.
  assign pend_d = (pend_q & ~clr) | (bus.irq_src & ~src_q);
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    timer_d = timer_q;
    rr_d = rr_q;
    clr = '0;
    if (state_q == IDLE && grant_valid) begin
      state_d = REQUEST;
      cause_d = grant_id;
      timer_d = '0;
    end else if (state_q == REQUEST) begin
      timer_d = timer_q + 8'd1;
      if (bus.irq_taken) begin
        state_d = SERVICE;
        clr[cause_q] = 1'b1;
        rr_d = !ROUND_ROBIN ? '0 : cause_q == SRC_W'(NUM_SOURCES - 1) ? '0 : cause_q + 1'b1;
      end else if (!bus.irq_enable[cause_q] || timer_q == 8'(TIMEOUT_CYCLES - 1)) begin
        state_d = IDLE;
      end
    end else if (state_q == SERVICE && bus.pc_mux_control == PC_SAVE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge instr_clock) begin
    if (!reset_n) begin
      state_q <= IDLE;
      src_q <= '0;
      pend_q <= '0;
      cause_q <= '0;
      rr_q <= '0;
      timer_q <= '0;
      irq_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q <= bus.irq_src;
      pend_q <= pend_d;
      cause_q <= cause_d;
      rr_q <= rr_d;
      timer_q <= timer_d;
      irq_q <= state_d == REQUEST;
      busy_q <= state_d == SERVICE;
    end
  end
  assign bus.irq = irq_q;
  assign bus.irq_busy = busy_q;
  assign bus.irq_cause = cause_q;
  assign bus.irq_pending = pend_q;
endmodule

// File: tb/tb_irq_arbiter.sv
// tb_irq_arbiter: directed-vector bench for fixed-priority and round-robin arbiters
module tb_irq_arbiter;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int vectors = 0;
  int miscompares = 0;
  always #5 clk = ~clk;
  irq_arbiter_if #(.NUM_SOURCES(4)) f();
  irq_arbiter_if #(.NUM_SOURCES(4)) r();
  irq_arbiter #(.NUM_SOURCES(4), .ROUND_ROBIN(1'b0), .TIMEOUT_CYCLES(15)) dut_f (
    .instr_clock(clk), .reset_n(reset_n), .bus(f));
  irq_arbiter #(.NUM_SOURCES(4), .ROUND_ROBIN(1'b1), .TIMEOUT_CYCLES(15)) dut_r (
    .instr_clock(clk), .reset_n(reset_n), .bus(r));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    f.irq_src = 4'h0; f.irq_enable = 4'hF; f.irq_taken = 1'b0; f.pc_mux_control = 2'h0;
    r.irq_src = 4'h0; r.irq_enable = 4'hF; r.irq_taken = 1'b0; r.pc_mux_control = 2'h0;
    reset_n = 1'b0;
    tick(); tick();
    vectors++; if ({f.irq, f.irq_busy, f.irq_cause, f.irq_pending} !== 8'h00) begin miscompares++; $display("FAIL reset_fixed got %b want 00000000", {f.irq, f.irq_busy, f.irq_cause, f.irq_pending}); end
    vectors++; if ({r.irq, r.irq_busy, r.irq_cause, r.irq_pending} !== 8'h00) begin miscompares++; $display("FAIL reset_rr got %b want 00000000", {r.irq, r.irq_busy, r.irq_cause, r.irq_pending}); end
    reset_n = 1'b1;
  endtask

  task automatic test_single();
    f.irq_src = 4'b0100;
    tick();
    vectors++; if ({f.irq, f.irq_pending} !== 5'b00100) begin miscompares++; $display("FAIL single_latch got irq,pend=%b want 00100", {f.irq, f.irq_pending}); end
    f.irq_src = 4'b0000;
    tick();
    vectors++; if ({f.irq, f.irq_cause} !== 3'b110) begin miscompares++; $display("FAIL single_req got irq,cause=%b want 110", {f.irq, f.irq_cause}); end
    f.irq_taken = 1'b1;
    tick();
    f.irq_taken = 1'b0;
    vectors++; if ({f.irq, f.irq_busy, f.irq_pending} !== 6'b010000) begin miscompares++; $display("FAIL single_taken got irq,busy,pend=%b want 010000", {f.irq, f.irq_busy, f.irq_pending}); end
    f.pc_mux_control = 2'h3;
    tick();
    f.pc_mux_control = 2'h0;
    vectors++; if ({f.irq, f.irq_busy, f.irq_cause} !== 4'b0010) begin miscompares++; $display("FAIL single_rfi got irq,busy,cause=%b want 0010", {f.irq, f.irq_busy, f.irq_cause}); end
  endtask

  task automatic test_fixed_priority();
    f.irq_src = 4'b1010;
    tick();
    f.irq_src = 4'b0000;
    vectors++; if (f.irq_pending !== 4'b1010) begin miscompares++; $display("FAIL fixed_pend0 got %b want 1010", f.irq_pending); end
    tick();
    vectors++; if ({f.irq, f.irq_cause} !== 3'b101) begin miscompares++; $display("FAIL fixed_first got irq,cause=%b want 101", {f.irq, f.irq_cause}); end
    f.irq_taken = 1'b1; tick(); f.irq_taken = 1'b0;
    vectors++; if (f.irq_pending !== 4'b1000) begin miscompares++; $display("FAIL fixed_pend1 got %b want 1000", f.irq_pending); end
    f.pc_mux_control = 2'h3; tick(); f.pc_mux_control = 2'h0;
    tick();
    vectors++; if ({f.irq, f.irq_cause} !== 3'b111) begin miscompares++; $display("FAIL fixed_second got irq,cause=%b want 111", {f.irq, f.irq_cause}); end
    f.irq_taken = 1'b1; tick(); f.irq_taken = 1'b0;
    vectors++; if (f.irq_pending !== 4'b0000) begin miscompares++; $display("FAIL fixed_pend2 got %b want 0000", f.irq_pending); end
    f.pc_mux_control = 2'h3; tick(); f.pc_mux_control = 2'h0;
  endtask

  task automatic test_round_robin();
    logic [1:0] want [4] = '{2'd0, 2'd1, 2'd0, 2'd1};
    for (int i = 0; i < 4; i++) begin
      r.irq_src = 4'b0011; tick();
      r.irq_src = 4'b0000; tick();
      vectors++; if ({r.irq, r.irq_cause} !== {1'b1, want[i]}) begin miscompares++; $display("FAIL rr_turn%0d got irq,cause=%b want 1%b", i, {r.irq, r.irq_cause}, want[i]); end
      r.irq_taken = 1'b1; tick(); r.irq_taken = 1'b0;
      r.pc_mux_control = 2'h3; tick(); r.pc_mux_control = 2'h0;
    end
  endtask

  task automatic test_timeout();
    int cnt = 0;
    f.irq_src = 4'b0010; tick();
    f.irq_src = 4'b0000; tick();
    for (int i = 0; i < 40 && f.irq; i++) begin
      cnt++;
      tick();
    end
    vectors++; if (cnt !== 15) begin miscompares++; $display("FAIL timeout_len got %0d want 15", cnt); end
    vectors++; if ({f.irq, f.irq_pending} !== 5'b00010) begin miscompares++; $display("FAIL timeout_gap got irq,pend=%b want 00010", {f.irq, f.irq_pending}); end
    tick();
    vectors++; if ({f.irq, f.irq_cause, f.irq_pending} !== 7'b1010010) begin miscompares++; $display("FAIL timeout_rearm got irq,cause,pend=%b want 1010010", {f.irq, f.irq_cause, f.irq_pending}); end
    f.irq_taken = 1'b1; tick(); f.irq_taken = 1'b0;
    f.pc_mux_control = 2'h3; tick(); f.pc_mux_control = 2'h0;
  endtask

  task automatic test_mask();
    f.irq_src = 4'b0001; tick();
    f.irq_src = 4'b0000; tick();
    vectors++; if ({f.irq, f.irq_cause} !== 3'b100) begin miscompares++; $display("FAIL mask_req got irq,cause=%b want 100", {f.irq, f.irq_cause}); end
    f.irq_enable = 4'b1110; tick();
    vectors++; if ({f.irq, f.irq_pending} !== 5'b00001) begin miscompares++; $display("FAIL mask_withdraw got irq,pend=%b want 00001", {f.irq, f.irq_pending}); end
    tick();
    vectors++; if (f.irq !== 1'b0) begin miscompares++; $display("FAIL mask_hold got %b want 0", f.irq); end
    f.irq_enable = 4'hF; tick();
    vectors++; if ({f.irq, f.irq_cause} !== 3'b100) begin miscompares++; $display("FAIL mask_reenable got irq,cause=%b want 100", {f.irq, f.irq_cause}); end
    f.irq_src = 4'b0001; f.irq_taken = 1'b1; tick();
    f.irq_src = 4'b0000; f.irq_taken = 1'b0;
    vectors++; if ({f.irq_busy, f.irq_pending} !== 5'b10001) begin miscompares++; $display("FAIL mask_set_wins got busy,pend=%b want 10001", {f.irq_busy, f.irq_pending}); end
    f.pc_mux_control = 2'h3; tick(); f.pc_mux_control = 2'h0;
    tick();
    vectors++; if ({f.irq, f.irq_cause} !== 3'b100) begin miscompares++; $display("FAIL mask_repeat got irq,cause=%b want 100", {f.irq, f.irq_cause}); end
    f.irq_taken = 1'b1; tick(); f.irq_taken = 1'b0;
    f.pc_mux_control = 2'h3; tick(); f.pc_mux_control = 2'h0;
  endtask

  task automatic test_reset_mid_service();
    f.irq_src = 4'b0100; tick();
    f.irq_src = 4'b0000; tick();
    f.irq_taken = 1'b1; tick(); f.irq_taken = 1'b0;
    f.irq_src = 4'b1000; tick();
    f.irq_src = 4'b0000;
    vectors++; if ({f.irq_busy, f.irq_cause, f.irq_pending} !== 7'b1101000) begin miscompares++; $display("FAIL mid_service got busy,cause,pend=%b want 1101000", {f.irq_busy, f.irq_cause, f.irq_pending}); end
    reset_n = 1'b0; tick(); reset_n = 1'b1;
    vectors++; if ({f.irq, f.irq_busy, f.irq_cause, f.irq_pending} !== 8'h00) begin miscompares++; $display("FAIL mid_reset got %b want 00000000", {f.irq, f.irq_busy, f.irq_cause, f.irq_pending}); end
    f.pc_mux_control = 2'h3; tick(); f.pc_mux_control = 2'h0;
    tick();
    vectors++; if ({f.irq, f.irq_busy, f.irq_pending} !== 6'b000000) begin miscompares++; $display("FAIL mid_rfi_ignored got irq,busy,pend=%b want 000000", {f.irq, f.irq_busy, f.irq_pending}); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fixed_priority();
    test_round_robin();
    test_timeout();
    test_mask();
    test_reset_mid_service();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
endmodule
